// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS-style coprocessor-0 control block.
// Holds Count/Compare timers, Status, Cause, EPC, BadVAddr and the read-only
// PRId/Config identifiers. It takes exception/ERET events from the pipeline
// and raises an interrupt request.
// Ports:
//    clk, rst          clock, synchronous active-high reset
//    raddr_i/rdata_o   combinational register read port
//    we_i/waddr_i/wdata_i  MTC0 write port
//    int_i             external interrupt levels
//    exc_*_i, eret_i   exception entry / return events
//    status_o, cause_o, epc_o, count_o  register mirrors
//    timer_int_o       per-compare-channel pending flags
//    int_req_o         interrupt request to the pipeline
module cp0_ctrl #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned NUM_HW_INT = 6,
   parameter int unsigned NUM_CMP    = 1,
   parameter int unsigned COUNT_DIV  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4:0]            raddr_i,
   output logic [DATA_W-1:0]     rdata_o,
   input  logic                  we_i,
   input  logic [4:0]            waddr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [NUM_HW_INT-1:0] int_i,
   input  logic                  exc_valid_i,
   input  logic [4:0]            exc_code_i,
   input  logic [DATA_W-1:0]     exc_pc_i,
   input  logic                  exc_in_delayslot_i,
   input  logic [DATA_W-1:0]     exc_badvaddr_i,
   input  logic                  eret_i,
   output logic [DATA_W-1:0]     status_o,
   output logic [DATA_W-1:0]     cause_o,
   output logic [DATA_W-1:0]     epc_o,
   output logic [DATA_W-1:0]     count_o,
   output logic [NUM_CMP-1:0]    timer_int_o,
   output logic                  int_req_o
);

   if (DATA_W != 32) begin : g_bad_data_w
      $error("cp0_ctrl: DATA_W must be 32");
   end
   if (NUM_HW_INT < 1 || NUM_HW_INT > 6) begin : g_bad_num_hw_int
      $error("cp0_ctrl: NUM_HW_INT must be 1..6");
   end
   if (NUM_CMP < 1 || NUM_CMP > 4) begin : g_bad_num_cmp
      $error("cp0_ctrl: NUM_CMP must be 1..4");
   end
   if (COUNT_DIV < 1 || COUNT_DIV > 256) begin : g_bad_count_div
      $error("cp0_ctrl: COUNT_DIV must be 1..256");
   end

   localparam logic [7:0]        PRESC_MAX = 8'(COUNT_DIV - 1);
   localparam logic [DATA_W-1:0] PRID_VAL  = 32'h004C_0102;
   localparam logic [DATA_W-1:0] CFG_VAL   = 32'h0000_8000;
   localparam logic [DATA_W-1:0] STAT_RST  = 32'h1000_0000;

   logic [7:0]        presc_q, presc_d;
   logic [DATA_W-1:0] count_q, count_d;
   logic [DATA_W-1:0] status_q, status_d;
   logic [DATA_W-1:0] cause_q, cause_d;
   logic [DATA_W-1:0] epc_q, epc_d;
   logic [DATA_W-1:0] badvaddr_q, badvaddr_d;
   logic [DATA_W-1:0] cmp_q [NUM_CMP];
   logic [DATA_W-1:0] cmp_d [NUM_CMP];
   logic [NUM_CMP-1:0] timer_q, timer_d;
   logic               inc;

   // Compare0 lives at 11; extra channels k>=1 sit at 21+k.
   function automatic logic [4:0] cmp_addr(input int unsigned k);
      return (k == 0) ? 5'd11 : 5'(21 + k);
   endfunction

   always_comb begin
      inc     = (presc_q == PRESC_MAX);
      presc_d = inc ? '0 : presc_q + 8'd1;
      count_d = inc ? count_q + 1'b1 : count_q;
      if (we_i && waddr_i == 5'd9) begin
         count_d = wdata_i;
         presc_d = '0;
      end

      // Match uses the pre-increment Count; a Compare write clears the
      // flag even if a match happens in the same cycle.
      for (int unsigned k = 0; k < NUM_CMP; k++) begin
         cmp_d[k]   = cmp_q[k];
         timer_d[k] = timer_q[k] | (inc && cmp_q[k] != '0 && count_q == cmp_q[k]);
         if (we_i && waddr_i == cmp_addr(k)) begin
            cmp_d[k]   = wdata_i;
            timer_d[k] = 1'b0;
         end
      end

      status_d   = status_q;
      epc_d      = epc_q;
      cause_d    = cause_q;
      badvaddr_d = badvaddr_q;
      if (we_i && waddr_i == 5'd12) status_d = wdata_i;
      if (we_i && waddr_i == 5'd14) epc_d = wdata_i;
      if (we_i && waddr_i == 5'd13) begin
         cause_d[23:22] = wdata_i[23:22];
         cause_d[9:8]   = wdata_i[9:8];
      end

      cause_d[15:10] = '0;
      for (int unsigned i = 0; i < NUM_HW_INT; i++) begin
         cause_d[10 + i] = int_i[i];
      end
      cause_d[15] = cause_d[15] | (|timer_q);

      // Exception applied after MTC0 so it overrides only the fields it owns.
      if (exc_valid_i) begin
         status_d[1]   = 1'b1;
         cause_d[6:2]  = exc_code_i;
         if (!status_q[1]) begin
            cause_d[31] = exc_in_delayslot_i;
            epc_d       = exc_in_delayslot_i ? exc_pc_i - 32'd4 : exc_pc_i;
         end
         if (exc_code_i == 5'd4 || exc_code_i == 5'd5) badvaddr_d = exc_badvaddr_i;
      end else if (eret_i) begin
         status_d[1] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q    <= '0;
         count_q    <= '0;
         status_q   <= STAT_RST;
         cause_q    <= '0;
         epc_q      <= '0;
         badvaddr_q <= '0;
         timer_q    <= '0;
         for (int unsigned k = 0; k < NUM_CMP; k++) cmp_q[k] <= '0;
      end else begin
         presc_q    <= presc_d;
         count_q    <= count_d;
         status_q   <= status_d;
         cause_q    <= cause_d;
         epc_q      <= epc_d;
         badvaddr_q <= badvaddr_d;
         timer_q    <= timer_d;
         for (int unsigned k = 0; k < NUM_CMP; k++) cmp_q[k] <= cmp_d[k];
      end
   end

   always_comb begin
      rdata_o = '0;
      if (!rst) begin
         case (raddr_i)
            5'd8:    rdata_o = badvaddr_q;
            5'd9:    rdata_o = count_q;
            5'd12:   rdata_o = status_q;
            5'd13:   rdata_o = cause_q;
            5'd14:   rdata_o = epc_q;
            5'd15:   rdata_o = PRID_VAL;
            5'd16:   rdata_o = CFG_VAL;
            default: rdata_o = '0;
         endcase
         for (int unsigned k = 0; k < NUM_CMP; k++) begin
            if (raddr_i == cmp_addr(k)) rdata_o = cmp_q[k];
         end
      end
   end

   assign status_o    = status_q;
   assign cause_o     = cause_q;
   assign epc_o       = epc_q;
   assign count_o     = count_q;
   assign timer_int_o = timer_q;
   assign int_req_o   = status_q[0] & ~status_q[1] & (|(cause_q[15:8] & status_q[15:8]));

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed checks of cp0_ctrl. Instance dut uses two compare
// channels at full Count rate; instance dut4 uses a divide-by-4 prescaler
// and is only checked right after reset release.
module tb_cp0_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  raddr_i, waddr_i, exc_code_i;
   logic        we_i, exc_valid_i, exc_in_delayslot_i, eret_i;
   logic [31:0] wdata_i, exc_pc_i, exc_badvaddr_i;
   logic [5:0]  int_i;
   logic [31:0] rdata_o, status_o, cause_o, epc_o, count_o;
   logic [1:0]  timer_int_o;
   logic        int_req_o;
   logic [31:0] rdata4, status4, cause4, epc4, count4;
   logic [0:0]  timer4;
   logic        int_req4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cp0_ctrl #(.DATA_W(32), .NUM_HW_INT(6), .NUM_CMP(2), .COUNT_DIV(1)) dut (
      .clk(clk), .rst(rst), .raddr_i(raddr_i), .rdata_o(rdata_o),
      .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .int_i(int_i),
      .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
      .exc_in_delayslot_i(exc_in_delayslot_i), .exc_badvaddr_i(exc_badvaddr_i),
      .eret_i(eret_i), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
      .count_o(count_o), .timer_int_o(timer_int_o), .int_req_o(int_req_o)
   );

   cp0_ctrl #(.DATA_W(32), .NUM_HW_INT(6), .NUM_CMP(1), .COUNT_DIV(4)) dut4 (
      .clk(clk), .rst(rst), .raddr_i(raddr_i), .rdata_o(rdata4),
      .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .int_i(int_i),
      .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
      .exc_in_delayslot_i(exc_in_delayslot_i), .exc_badvaddr_i(exc_badvaddr_i),
      .eret_i(eret_i), .status_o(status4), .cause_o(cause4), .epc_o(epc4),
      .count_o(count4), .timer_int_o(timer4), .int_req_o(int_req4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      we_i = 1'b1; waddr_i = a; wdata_i = d;
      tick();
      we_i = 1'b0;
   endtask

   task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc,
                            input logic ds, input logic [31:0] bva);
      exc_valid_i = 1'b1; exc_code_i = code; exc_pc_i = pc;
      exc_in_delayslot_i = ds; exc_badvaddr_i = bva;
      tick();
      exc_valid_i = 1'b0; exc_in_delayslot_i = 1'b0;
   endtask

   initial begin
      rst = 1'b1; raddr_i = 5'd15; waddr_i = '0; wdata_i = '0; we_i = 1'b0;
      int_i = '0; exc_valid_i = 1'b0; exc_code_i = '0; exc_pc_i = '0;
      exc_in_delayslot_i = 1'b0; exc_badvaddr_i = '0; eret_i = 1'b0;

      // Reset state
      tick(); tick();
      check("rst_rdata", rdata_o, 32'h0);
      check("rst_status", status_o, 32'h1000_0000);
      check("rst_cause", cause_o, 32'h0);
      check("rst_count", count_o, 32'h0);
      check("rst_timer", {30'b0, timer_int_o}, 32'h0);
      check("rst_intreq", {31'b0, int_req_o}, 32'h0);
      rst = 1'b0;
      #1 check("prid", rdata_o, 32'h004C_0102);
      raddr_i = 5'd16;
      #1 check("config", rdata_o, 32'h0000_8000);

      // Prescaler: divide-by-4 and divide-by-1 instances
      repeat (4) tick();
      check("div4_cnt4", count4, 32'd1);
      check("div1_cnt4", count_o, 32'd4);
      repeat (8) tick();
      check("div4_cnt12", count4, 32'd3);
      check("div1_cnt12", count_o, 32'd12);

      // Compare channel 1
      mtc0(5'd22, 32'd5);
      mtc0(5'd9, 32'd0);
      check("cnt_write", count_o, 32'd0);
      raddr_i = 5'd22;
      #1 check("rd_cmp1", rdata_o, 32'd5);
      raddr_i = 5'd23;
      #1 check("rd_absent_cmp", rdata_o, 32'd0);
      repeat (5) tick();
      check("cnt5", count_o, 32'd5);
      check("timer_before", {30'b0, timer_int_o}, 32'h0);
      tick();
      check("timer1_set", {30'b0, timer_int_o}, 32'h2);
      mtc0(5'd22, 32'd9);
      check("timer1_clr", {30'b0, timer_int_o}, 32'h0);

      // Timer 0 interrupt, then exception in delay slot
      mtc0(5'd22, 32'd0);
      mtc0(5'd12, 32'h0000_8001);
      mtc0(5'd11, 32'd3);
      mtc0(5'd9, 32'd0);
      repeat (5) tick();
      check("timer0_set", {30'b0, timer_int_o}, 32'h1);
      check("cause_ip7", cause_o, 32'h0000_8000);
      check("intreq_on", {31'b0, int_req_o}, 32'h1);
      raise_exc(5'd0, 32'h100, 1'b1, 32'h0);
      check("exc_epc", epc_o, 32'h0000_00FC);
      check("exc_cause", cause_o, 32'h8000_8000);
      check("exc_status", status_o, 32'h0000_8003);
      check("exc_intreq", {31'b0, int_req_o}, 32'h0);

      // Nested exception with EXL set: EPC/BD kept, BadVAddr captured
      raise_exc(5'd5, 32'h200, 1'b0, 32'h1003);
      check("nest_epc", epc_o, 32'h0000_00FC);
      check("nest_cause", cause_o, 32'h8000_8014);
      raddr_i = 5'd8;
      #1 check("badvaddr", rdata_o, 32'h0000_1003);
      eret_i = 1'b1; tick(); eret_i = 1'b0;
      check("eret_status", status_o, 32'h0000_8001);
      check("eret_intreq", {31'b0, int_req_o}, 32'h1);

      // MTC0 Status collides with exception; code 8 leaves BadVAddr alone
      we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h1;
      raise_exc(5'd8, 32'h300, 1'b0, 32'hDEAD);
      we_i = 1'b0;
      check("coll_status", status_o, 32'h0000_0003);
      check("coll_epc", epc_o, 32'h0000_0300);
      check("coll_cause", cause_o, 32'h0000_8020);
      #1 check("badv_kept", rdata_o, 32'h0000_1003);
      eret_i = 1'b1; tick(); eret_i = 1'b0;
      check("eret2_status", status_o, 32'h0000_0001);

      // Reset mid-operation (timer pending, EXL set) beats write/exception
      raise_exc(5'd0, 32'h400, 1'b0, 32'h0);
      rst = 1'b1; we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'hFFFF_FFFF;
      exc_valid_i = 1'b1;
      tick();
      check("mid_rst_status", status_o, 32'h1000_0000);
      check("mid_rst_timer", {30'b0, timer_int_o}, 32'h0);
      check("mid_rst_epc", epc_o, 32'h0);
      check("mid_rst_cause", cause_o, 32'h0);
      rst = 1'b0; we_i = 1'b0; exc_valid_i = 1'b0;

      // Unmapped read, Cause write mask, RO write ignored, EPC write
      raddr_i = 5'd20;
      #1 check("rd_unmapped", rdata_o, 32'h0);
      mtc0(5'd13, 32'hFFFF_FFFF);
      check("cause_mask", cause_o, 32'h00C0_0300);
      mtc0(5'd8, 32'h1234_5678);
      raddr_i = 5'd8;
      #1 check("badv_ro", rdata_o, 32'h0);
      mtc0(5'd14, 32'h0000_1234);
      check("epc_write", epc_o, 32'h0000_1234);

      // Hardware interrupt line 0 -> IP2, one cycle latency
      int_i = 6'b000001;
      mtc0(5'd12, 32'h0000_0401);
      check("hwint_cause", cause_o, 32'h00C0_0700);
      check("hwint_intreq", {31'b0, int_req_o}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, CP0 register width; only 32 supported, other values rejected at elaboration.
REQ-002 SHALL provide parameter NUM_HW_INT, default 6, external interrupt lines, legal 1..6.
REQ-003 SHALL provide parameter NUM_CMP, default 1, timer compare channels, legal 1..4.
REQ-004 SHALL provide parameter COUNT_DIV, default 1, clk cycles per Count increment, legal 1..256.
REQ-005 SHALL provide ports: clk in 1 clock; rst in 1 reset. One clock; reset synchronous, active-high.
REQ-006 SHALL provide ports: raddr_i in 5 read address; rdata_o out DATA_W read data.
REQ-007 SHALL provide ports: we_i in 1 write enable; waddr_i in 5 write address; wdata_i in DATA_W write data.
REQ-008 SHALL provide ports: int_i in NUM_HW_INT external interrupt levels.
REQ-009 SHALL provide ports: exc_valid_i in 1; exc_code_i in 5 ExcCode; exc_pc_i in DATA_W faulting PC; exc_in_delayslot_i in 1; exc_badvaddr_i in DATA_W; eret_i in 1.
REQ-010 SHALL provide ports: status_o, cause_o, epc_o, count_o out DATA_W register mirrors; timer_int_o out NUM_CMP per-channel pending; int_req_o out 1 interrupt request to pipeline.

Function
REQ-011 Register map: BadVAddr 8 (read-only), Count 9, Compare0 11, Status 12, Cause 13, EPC 14, PRId 15 (RO), Config 16 (RO), Compare k (k=1..NUM_CMP-1) at 21+k.
REQ-012 rdata_o combinational from current register state; unmapped or absent-channel address returns 0; no write bypass (same-cycle read of written address returns old value); rdata_o = 0 while rst high.
REQ-013 Prescaler: counts 0..COUNT_DIV-1; Count += 1 (mod 2^32) on the cycle prescaler reaches COUNT_DIV-1, then prescaler returns to 0; COUNT_DIV=1 means increment every cycle.
REQ-014 MTC0 Count: Count <= wdata_i, prescaler <= 0; write wins over same-cycle increment.
REQ-015 Timer k: when Compare k != 0 and Count == Compare k on an increment cycle (pre-increment value), timer_int_o[k] set next cycle; stays set until MTC0 to Compare k.
REQ-016 MTC0 Compare k: Compare k <= wdata_i, timer_int_o[k] <= 0; clear wins over same-cycle match.
REQ-017 MTC0 Status: all 32 bits writable. MTC0 Cause: only IP[9:8], bits 22, 23 writable. MTC0 to EPC writable; to RO/unmapped addresses ignored.
REQ-018 Cause[10+i] <= int_i[i] every cycle for i<NUM_HW_INT (registered, 1-cycle latency); Cause[15] additionally ORs |timer_int_o; unused IP bits read 0.
REQ-019 int_req_o = Status[0] (IE) & ~Status[1] (EXL) & |(Cause[15:8] & Status[15:8]), combinational from registers.
REQ-020 exc_valid_i: if EXL==0, EPC <= exc_pc_i - 4 and Cause[31] <= 1 when in delay slot, else EPC <= exc_pc_i and Cause[31] <= 0; if EXL==1, EPC and BD unchanged; in all cases EXL <= 1, Cause[6:2] <= exc_code_i.
REQ-021 exc_code_i 4 (AdEL) or 5 (AdES): BadVAddr <= exc_badvaddr_i; other codes leave BadVAddr unchanged.
REQ-022 eret_i (exc_valid_i low): EXL <= 0. exc_valid_i and eret_i together: exception wins, eret ignored.
REQ-023 Same-cycle priority: exception update overrides MTC0 write to Status, Cause, or EPC fields it touches; untouched fields still take the MTC0 write.
REQ-024 status_o, cause_o, epc_o, count_o reflect register values, updated on the same clk edge as the register.

Reset
REQ-025 On rst high at clk edge: Count, all Compare, Cause, EPC, BadVAddr, prescaler, timer_int_o = 0; Status = 0x1000_0000; Config = 0x0000_8000; PRId = 0x004C_0102; int_req_o = 0.
REQ-026 Reset mid-operation (pending timer, EXL set) clears all state on the next edge; no exception or write takes effect that cycle.

Verification
REQ-027 COUNT_DIV=4, reset release, no writes -> count_o = 1 after 4 cycles, = 3 after 12 cycles.
REQ-028 NUM_CMP=2, COUNT_DIV=1: write Compare1 (addr 22) = 5, Count = 0 -> timer_int_o = 2'b10 one cycle after Count increments from 5; write Compare1 = 9 -> timer_int_o = 0 next cycle.
REQ-029 Status = 0x0000_8001, Compare0 = 3 -> Cause[15] = 1, int_req_o = 1; exc_valid_i, code 0, pc 0x100, delay slot -> EPC = 0xFC, Cause[31] = 1, EXL = 1, int_req_o = 0.
REQ-030 With EXL = 1, exc_valid_i code 5, pc 0x200, badvaddr 0x1003 -> EPC unchanged, ExcCode = 5, BadVAddr = 0x1003.
REQ-031 Same cycle: MTC0 Status = 0x0000_0001 and exc_valid_i code 8 -> Status = 0x0000_0003; then eret_i -> Status = 0x0000_0001.
REQ-032 Read addr 20 -> rdata_o = 0; MTC0 Cause = 0xFFFF_FFFF with int_i = 0 -> Cause = 0x00C0_0300.
